inst_mem_burst_slave: RTL and testbench
=======================================

Name: inst_mem_burst_slave

Overview:
Avalon-MM style burst-read responder modelling instruction memory. It is the memory-side counterpart of the instruction fetch controller's burst read master. It accepts one read command (address + burstcount) at a time. After a fixed latency it returns burstcount consecutive words on readdata/readdatavalid. A side load port preloads or patches memory contents, and a stall input lets benches insert gaps between beats.

Parameters:
p_addr_bits, 18, width of word address (i_addr, i_load_addr)
p_data_bits, 32, width of a memory word / readdata
p_burst_bits, 4, width of i_burstcount
p_mem_depth_log2, 10, memory holds 2^p_mem_depth_log2 words; address LSBs index it
p_read_latency, 2, edges from command accept to first beat (legal range 1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
i_read  in  1  read command request
i_addr  in  p_addr_bits  burst start word address
i_burstcount  in  p_burst_bits  beats requested
o_waitrequest  out  1  high = command not accepted this cycle
o_readdata  out  p_data_bits  returned word
o_readdatavalid  out  1  o_readdata valid this cycle
i_stall  in  1  high = suppress beat at this edge
i_load_we  in  1  memory write strobe
i_load_addr  in  p_addr_bits  memory write address
i_load_data  in  p_data_bits  memory write data
o_busy  out  1  burst in progress (not IDLE)

Behaviour:
- Reset (rst high at edge): state=IDLE, o_waitrequest=1, o_readdatavalid=0, o_readdata=0, o_busy=0, counters=0. Memory contents are not cleared. After the first edge with rst low: o_waitrequest=0.
- Reset mid-burst aborts immediately. No further beats are issued. Remaining beats are lost.
- All outputs are registered.
- States: IDLE, LAT, BURST.
- IDLE: o_waitrequest=0. On an edge with i_read=1:
  - Capture addr and burstcount.
  - If burstcount=0: command consumed, stay IDLE, no beats.
  - If burstcount=1..2^p_burst_bits-1: latency counter = p_read_latency-1, go to LAT, o_waitrequest=1, o_busy=1.
  - With p_read_latency=1, go straight to BURST.
- LAT: decrement the counter each edge. When it reaches 0, go to BURST. i_stall is ignored in LAT.
- BURST, each edge:
  - i_stall=0: o_readdatavalid=1, o_readdata=mem[addr], addr+=1, remaining-=1.
  - i_stall=1: o_readdatavalid=0, addr and remaining held.
  - After the last beat is issued: go to IDLE. o_waitrequest=0 and o_busy=0 are visible in the cycle after the last beat.
- Latency: command accepted at edge k. First beat is visible after edge k+p_read_latency (no stall). Beats are consecutive.
- Address: only the low p_mem_depth_log2 bits index memory. Increment wraps modulo 2^p_mem_depth_log2. Upper address bits are ignored.
- i_read while o_waitrequest=1 is ignored. The master must hold the command until accepted.
- Load port: when i_load_we=1 at an edge, mem[i_load_addr low bits]=i_load_data. Writes are legal in any state.
- Load write to the address read by a beat at the same edge: the beat returns the OLD value (read-before-write).
- o_readdata holds its last value while o_readdatavalid=0.

Test Plan:
- Reset then idle: rst high 4 cycles -> o_waitrequest=1, o_readdatavalid=0 during reset. o_waitrequest=0 one cycle after release.
- Preload mem[i]=0x100+i for i=0..15. Read addr=4, burstcount=4, latency 2 -> waitrequest high from the next cycle. Beats 0x104,0x105,0x106,0x107 begin 2 edges after accept and run back-to-back. waitrequest low after the last beat.
- Same burst with i_stall high on the 2nd beat edge only -> data 0x104, gap (valid=0), 0x105, 0x106, 0x107. Total 5 cycles.
- Wrap: depth 1024, preload mem[1022]=0xA, mem[1023]=0xB, mem[0]=0xC. Read addr=0x3FE, count 3 -> 0xA, 0xB, 0xC. Also addr=0x3FFFE (upper bits set) -> same data.
- burstcount=0 with i_read=1 -> no readdatavalid. o_waitrequest stays 0. The next command is accepted on the following cycle.
- Load write to mem[5]=0xDEAD on the same edge a beat reads addr 5 (old value 0x105) -> beat returns 0x105. A subsequent read of addr 5 returns 0xDEAD.
- rst asserted on the 2nd beat of a 4-beat burst -> readdatavalid=0 from the next cycle. State is IDLE and a new command is accepted after release.

Source files
------------

// File: rtl/inst_mem_burst_slave.sv
// Burst-read instruction memory responder: accepts one read command at a time and
// returns burstcount consecutive words after a fixed latency; a side port loads memory.
module inst_mem_burst_slave #(
  parameter int unsigned p_addr_bits      = 18,
  parameter int unsigned p_data_bits      = 32,
  parameter int unsigned p_burst_bits     = 4,
  parameter int unsigned p_mem_depth_log2 = 10,
  parameter int unsigned p_read_latency   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_read,
  input  logic [p_addr_bits-1:0] i_addr,
  input  logic [p_burst_bits-1:0] i_burstcount,
  output logic                   o_waitrequest,
  output logic [p_data_bits-1:0] o_readdata,
  output logic                   o_readdatavalid,
  input  logic                   i_stall,
  input  logic                   i_load_we,
  input  logic [p_addr_bits-1:0] i_load_addr,
  input  logic [p_data_bits-1:0] i_load_data,
  output logic                   o_busy
);

  localparam int unsigned DEPTH = 1 << p_mem_depth_log2;
  localparam int unsigned LAT_W = 4;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(p_read_latency - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAT,
    S_BURST
  } state_e;

  state_e                      state_q, state_d;
  logic [p_mem_depth_log2-1:0] addr_q, addr_d;
  logic [p_burst_bits-1:0]     remaining_q, remaining_d;
  logic [LAT_W-1:0]            lat_q, lat_d;
  logic                        waitrequest_q, waitrequest_d;
  logic                        readdatavalid_q, readdatavalid_d;
  logic [p_data_bits-1:0]      readdata_q, readdata_d;
  logic                        busy_q, busy_d;

  logic [p_data_bits-1:0]      mem [DEPTH];
  logic [p_data_bits-1:0]      rd_word;
  logic                        cmd_accept;

  // Upper address bits deliberately do not take part in indexing.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{i_addr[p_addr_bits-1:p_mem_depth_log2],
                            i_load_addr[p_addr_bits-1:p_mem_depth_log2]};

  // The beat reads the word before any load write at the same edge lands.
  assign rd_word    = mem[addr_q];
  assign cmd_accept = (state_q == S_IDLE) && i_read && !waitrequest_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    lat_d           = lat_q;
    waitrequest_d   = waitrequest_q;
    readdatavalid_d = 1'b0;
    readdata_d      = readdata_q;
    busy_d          = busy_q;

    unique case (state_q)
      S_IDLE: begin
        waitrequest_d = 1'b0;
        busy_d        = 1'b0;
        if (cmd_accept) begin
          addr_d      = i_addr[p_mem_depth_log2-1:0];
          remaining_d = i_burstcount;
          if (i_burstcount != '0) begin
            waitrequest_d = 1'b1;
            busy_d        = 1'b1;
            if (p_read_latency <= 1) begin
              state_d = S_BURST;
            end else begin
              lat_d   = LAT_INIT;
              state_d = S_LAT;
            end
          end
        end
      end

      S_LAT: begin
        if (lat_q <= LAT_W'(1)) begin
          lat_d   = '0;
          state_d = S_BURST;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      S_BURST: begin
        if (!i_stall) begin
          readdatavalid_d = 1'b1;
          readdata_d      = rd_word;
          addr_d          = addr_q + 1'b1;
          remaining_d     = remaining_q - 1'b1;
          if (remaining_q == p_burst_bits'(1)) begin
            state_d       = S_IDLE;
            waitrequest_d = 1'b0;
            busy_d        = 1'b0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      lat_q           <= '0;
      waitrequest_q   <= 1'b1;
      readdatavalid_q <= 1'b0;
      readdata_q      <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      lat_q           <= lat_d;
      waitrequest_q   <= waitrequest_d;
      readdatavalid_q <= readdatavalid_d;
      readdata_q      <= readdata_d;
      busy_q          <= busy_d;
    end
  end

  // NOTE: the memory array has no reset; contents survive rst and only the load port changes them.
  always_ff @(posedge clk) begin
    if (i_load_we) begin
      mem[i_load_addr[p_mem_depth_log2-1:0]] <= i_load_data;
    end
  end

  assign o_waitrequest   = waitrequest_q;
  assign o_readdatavalid = readdatavalid_q;
  assign o_readdata      = readdata_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_inst_mem_burst_slave.sv
// Directed bench for inst_mem_burst_slave: reset, bursts, stall gaps, wrap,
// zero-length command, read-before-write on the load port and mid-burst reset.
module tb_inst_mem_burst_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [17:0] i_addr;
  logic [3:0]  i_burstcount;
  logic        o_waitrequest;
  logic [31:0] o_readdata;
  logic        o_readdatavalid;
  logic        i_stall;
  logic        i_load_we;
  logic [17:0] i_load_addr;
  logic [31:0] i_load_data;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  inst_mem_burst_slave dut (
    .clk            (clk),
    .rst            (rst),
    .i_read         (i_read),
    .i_addr         (i_addr),
    .i_burstcount   (i_burstcount),
    .o_waitrequest  (o_waitrequest),
    .o_readdata     (o_readdata),
    .o_readdatavalid(o_readdatavalid),
    .i_stall        (i_stall),
    .i_load_we      (i_load_we),
    .i_load_addr    (i_load_addr),
    .i_load_data    (i_load_data),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] data);
    check({tag, "_valid"}, 32'(o_readdatavalid), 32'd1);
    check({tag, "_data"}, o_readdata, data);
  endtask

  task automatic load(input logic [17:0] a, input logic [31:0] d);
    i_load_we   = 1'b1;
    i_load_addr = a;
    i_load_data = d;
    tick();
    i_load_we   = 1'b0;
  endtask

  // Present a command for exactly one edge (slave is idle, so it is accepted).
  task automatic issue(input logic [17:0] a, input logic [3:0] n);
    i_read       = 1'b1;
    i_addr       = a;
    i_burstcount = n;
    tick();
    i_read       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_read = 1'b0; i_addr = '0; i_burstcount = '0;
    i_stall = 1'b0; i_load_we = 1'b0; i_load_addr = '0; i_load_data = '0;

    // Reset held for 4 edges
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_waitreq", 32'(o_waitrequest), 32'd1);
      check("rst_valid", 32'(o_readdatavalid), 32'd0);
    end
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_data", o_readdata, 32'd0);
    rst = 1'b0;
    tick();
    check("rel_waitreq", 32'(o_waitrequest), 32'd0);

    for (int i = 0; i < 16; i++) load(18'(i), 32'h100 + 32'(i));

    // Plain 4-beat burst from address 4
    issue(18'd4, 4'd4);
    check("b1_acc_waitreq", 32'(o_waitrequest), 32'd1);
    check("b1_acc_busy", 32'(o_busy), 32'd1);
    check("b1_acc_valid", 32'(o_readdatavalid), 32'd0);
    tick();
    check("b1_lat_valid", 32'(o_readdatavalid), 32'd0);
    tick(); expect_beat("b1_beat0", 32'h104);
    tick(); expect_beat("b1_beat1", 32'h105);
    tick(); expect_beat("b1_beat2", 32'h106);
    tick(); expect_beat("b1_beat3", 32'h107);
    check("b1_end_waitreq", 32'(o_waitrequest), 32'd0);
    check("b1_end_busy", 32'(o_busy), 32'd0);
    tick();
    check("b1_after_valid", 32'(o_readdatavalid), 32'd0);
    check("b1_after_hold", o_readdata, 32'h107);

    // Same burst, stall during latency (ignored) and on the 2nd beat edge
    issue(18'd4, 4'd4);
    i_stall = 1'b1;
    tick();
    check("b2_lat_valid", 32'(o_readdatavalid), 32'd0);
    i_stall = 1'b0;
    tick(); expect_beat("b2_beat0", 32'h104);
    i_stall = 1'b1;
    tick();
    check("b2_gap_valid", 32'(o_readdatavalid), 32'd0);
    check("b2_gap_hold", o_readdata, 32'h104);
    check("b2_gap_busy", 32'(o_busy), 32'd1);
    i_stall = 1'b0;
    tick(); expect_beat("b2_beat1", 32'h105);
    tick(); expect_beat("b2_beat2", 32'h106);
    tick(); expect_beat("b2_beat3", 32'h107);
    check("b2_end_waitreq", 32'(o_waitrequest), 32'd0);

    // Address wrap at the top of the 1024-word memory
    load(18'h3FE, 32'hA);
    load(18'h3FF, 32'hB);
    load(18'h000, 32'hC);
    issue(18'h003FE, 4'd3);
    tick();
    tick(); expect_beat("wrap_beat0", 32'hA);
    tick(); expect_beat("wrap_beat1", 32'hB);
    tick(); expect_beat("wrap_beat2", 32'hC);
    issue(18'h3FFFE, 4'd3);
    tick();
    tick(); expect_beat("wrap_hi_beat0", 32'hA);
    tick(); expect_beat("wrap_hi_beat1", 32'hB);
    tick(); expect_beat("wrap_hi_beat2", 32'hC);
    check("wrap_hi_end_waitreq", 32'(o_waitrequest), 32'd0);

    // Zero-length command is consumed without beats; next command accepted next cycle
    issue(18'd6, 4'd0);
    check("bc0_waitreq", 32'(o_waitrequest), 32'd0);
    check("bc0_busy", 32'(o_busy), 32'd0);
    check("bc0_valid", 32'(o_readdatavalid), 32'd0);
    issue(18'd6, 4'd1);
    check("bc0_next_waitreq", 32'(o_waitrequest), 32'd1);
    tick();
    check("bc0_next_lat_valid", 32'(o_readdatavalid), 32'd0);
    tick(); expect_beat("bc0_next_beat", 32'h106);
    check("bc0_next_end_waitreq", 32'(o_waitrequest), 32'd0);

    // Load write to the address a beat reads at the same edge returns the old word
    issue(18'd4, 4'd2);
    tick();
    tick(); expect_beat("rbw_beat0", 32'h104);
    i_load_we = 1'b1; i_load_addr = 18'd5; i_load_data = 32'hDEAD;
    tick(); expect_beat("rbw_beat1_old", 32'h105);
    i_load_we = 1'b0;
    issue(18'd5, 4'd1);
    tick();
    tick(); expect_beat("rbw_reread_new", 32'hDEAD);

    // Reset on the 2nd beat of a 4-beat burst aborts it
    issue(18'd8, 4'd4);
    tick();
    tick(); expect_beat("mrst_beat0", 32'h108);
    rst = 1'b1;
    tick();
    check("mrst_valid", 32'(o_readdatavalid), 32'd0);
    check("mrst_waitreq", 32'(o_waitrequest), 32'd1);
    check("mrst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    tick();
    check("mrst_rel_waitreq", 32'(o_waitrequest), 32'd0);
    check("mrst_rel_valid", 32'(o_readdatavalid), 32'd0);
    tick();
    check("mrst_no_more_beats", 32'(o_readdatavalid), 32'd0);
    issue(18'd9, 4'd1);
    check("mrst_new_acc", 32'(o_waitrequest), 32'd1);
    tick();
    tick(); expect_beat("mrst_new_beat", 32'h109);
    tick();
    check("mrst_new_after_valid", 32'(o_readdatavalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
